wb_select_pipe: RTL and testbench

- Parametrised writeback-source selector for the datapath; successor to the fixed 8-bit, 5-source writeback mux.
- Picks one of NUM_SRC WIDTH-bit result sources, registers the result with its destination tag and write enable, and hands it to the register file over a valid/ready handshake.
- A two-entry skid buffer gives full throughput under backpressure.
- Flags out-of-range selects and counts them.

---
 rtl/wb_select_pipe.sv | 133 +++++++++++++
 tb/tb_wb_select_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_pipe.sv
// wb_select_pipe: parametrised writeback-source selector.
//
// Picks one of NUM_SRC WIDTH-bit result sources, registers it together with
// its destination tag and write enable, and presents it to the register file
// over a valid/ready handshake. A second (skid) register holds one further
// beat, so full throughput is kept under backpressure while in_ready remains
// a plain flop output.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   src_data_i            packed sources, source k at [k*WIDTH +: WIDTH]
//   sel_i, dest_i, we_i   select, destination tag, write enable of input beat
//   in_valid / in_ready   input handshake
//   out_data/out_dest/out_we, out_valid / out_ready   output beat + handshake
//   flush                 synchronous discard of all buffered beats
//   err_clr               clears sel_err / err_count
//   sel_err, err_count    sticky bad-select flag, saturating bad-select count
module wb_select_pipe #(
  parameter int WIDTH       = 8,
  parameter int NUM_SRC     = 5,
  parameter int SEL_W       = 4,
  parameter int DEFAULT_SRC = 0,
  parameter int ADDR_W      = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [ADDR_W-1:0]        dest_i,
  input  logic                     we_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ADDR_W-1:0]        out_dest,
  output logic                     out_we,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic                     sel_err,
  output logic [ERR_CNT_W-1:0]     err_count
);

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] dest;
    logic              we;
  } beat_t;

  // Source unpack
  logic [WIDTH-1:0] src [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src[g] = src_data_i[g*WIDTH +: WIDTH];
  end

  // Input-side selection
  logic       sel_ok;
  beat_t      sel_beat;

  // Compare at 32 bits so NUM_SRC == 2**SEL_W does not wrap to zero.
  assign sel_ok = ({{(32-SEL_W){1'b0}}, sel_i} < 32'(NUM_SRC));

  always_comb begin
    sel_beat.data = src[DEFAULT_SRC];
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_ok && (sel_i == SEL_W'(k))) sel_beat.data = src[k];
    end
    sel_beat.dest = dest_i;
    // An out-of-range select must never write the register file.
    sel_beat.we   = we_i & sel_ok;
  end

  // Handshake
  logic  skid_valid;
  beat_t skid_q;
  beat_t out_q;
  logic  accept;
  logic  bad_acc;

  assign in_ready = ~skid_valid;             // flop-derived, no out_ready path
  assign accept   = in_valid & in_ready;
  // A flushed beat is discarded outright, including for error accounting.
  assign bad_acc  = accept & ~flush & ~sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Skid full implies out_valid; in_ready is low, so no accept here.
      if (out_ready) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_q     <= sel_beat;
        out_valid <= 1'b1;
      end else begin
        skid_q     <= sel_beat;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = out_q.data;
  assign out_dest = out_q.dest;
  assign out_we   = out_q.we;

  // Error tracking; a bad accept coinciding with err_clr counts as the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else if (err_clr) begin
      sel_err   <= bad_acc;
      err_count <= bad_acc ? ERR_CNT_W'(1) : '0;
    end else if (bad_acc) begin
      sel_err <= 1'b1;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_select_pipe.sv
module tb_wb_select_pipe;

  logic        clk;
  logic        rst_n;

  // DUT A: default build (WIDTH=8, NUM_SRC=5)
  logic [39:0] src_a;
  logic [3:0]  sel_a;
  logic [3:0]  dest_a;
  logic        we_a, inv_a, inr_a;
  logic [7:0]  od_a;
  logic [3:0]  odst_a;
  logic        owe_a, ov_a, ordy_a, flush_a, clr_a, serr_a;
  logic [7:0]  ecnt_a;

  // DUT B: WIDTH=16, NUM_SRC=12
  logic [191:0] src_b;
  logic [3:0]   sel_b;
  logic [3:0]   dest_b;
  logic         we_b, inv_b, inr_b;
  logic [15:0]  od_b;
  logic [3:0]   odst_b;
  logic         owe_b, ov_b, ordy_b, flush_b, clr_b, serr_b;
  logic [7:0]   ecnt_b;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  wb_select_pipe u_dut_a (
    .clk(clk), .rst_n(rst_n), .src_data_i(src_a), .sel_i(sel_a), .dest_i(dest_a),
    .we_i(we_a), .in_valid(inv_a), .in_ready(inr_a), .out_data(od_a),
    .out_dest(odst_a), .out_we(owe_a), .out_valid(ov_a), .out_ready(ordy_a),
    .flush(flush_a), .err_clr(clr_a), .sel_err(serr_a), .err_count(ecnt_a)
  );

  wb_select_pipe #(.WIDTH(16), .NUM_SRC(12), .SEL_W(4), .DEFAULT_SRC(0),
                   .ADDR_W(4), .ERR_CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .src_data_i(src_b), .sel_i(sel_b), .dest_i(dest_b),
    .we_i(we_b), .in_valid(inv_b), .in_ready(inr_b), .out_data(od_b),
    .out_dest(odst_b), .out_we(owe_b), .out_valid(ov_b), .out_ready(ordy_b),
    .flush(flush_b), .err_clr(clr_b), .sel_err(serr_b), .err_count(ecnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    inv_a = 0; sel_a = 0; dest_a = 0; we_a = 0; ordy_a = 0; flush_a = 0; clr_a = 0;
    inv_b = 0; sel_b = 0; dest_b = 0; we_b = 0; ordy_b = 0; flush_b = 0; clr_b = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({ov_a, inr_a, od_a, odst_a, owe_a, serr_a, ecnt_a} !== {1'b0, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_state: got ov=%b rdy=%b d=%h dst=%h we=%b err=%b cnt=%h, want 0 1 00 0 0 0 00",
               ov_a, inr_a, od_a, odst_a, owe_a, serr_a, ecnt_a);
    else pass_cnt++;
  endtask

  task automatic test_basic_select();
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    ordy_a = 1;
    for (int k = 0; k < 5; k++) begin
      sel_a = 4'(k); dest_a = 4'(k + 3); we_a = 1; inv_a = 1;
      step();
      chk_cnt++;
      if ({ov_a, inr_a, od_a, odst_a, owe_a} !== {1'b1, 1'b1, exp_d[k], 4'(k + 3), 1'b1})
        $display("FAIL basic_sel%0d: got v=%b rdy=%b d=%h dst=%h we=%b, want 1 1 %h %h 1",
                 k, ov_a, inr_a, od_a, odst_a, owe_a, exp_d[k], 4'(k + 3));
      else pass_cnt++;
    end
    inv_a = 0;
    step();
    chk_cnt++;
    if (ov_a !== 1'b0) $display("FAIL basic_drain: out_valid=%b want 0", ov_a);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ordy_a = 0; we_a = 1; dest_a = 4'h2;
    sel_a = 2; inv_a = 1;
    step();
    chk_cnt++;
    if ({ov_a, od_a, inr_a} !== {1'b1, 8'h33, 1'b1})
      $display("FAIL bp_first: got v=%b d=%h rdy=%b want 1 33 1", ov_a, od_a, inr_a);
    else pass_cnt++;
    sel_a = 4; dest_a = 4'h4;
    step();
    chk_cnt++;
    if ({ov_a, od_a, odst_a, inr_a} !== {1'b1, 8'h33, 4'h2, 1'b0})
      $display("FAIL bp_skid: got v=%b d=%h dst=%h rdy=%b want 1 33 2 0", ov_a, od_a, odst_a, inr_a);
    else pass_cnt++;
    inv_a = 0; sel_a = 0;
    step();
    chk_cnt++;
    if ({ov_a, od_a, inr_a} !== {1'b1, 8'h33, 1'b0})
      $display("FAIL bp_hold: got v=%b d=%h rdy=%b want 1 33 0", ov_a, od_a, inr_a);
    else pass_cnt++;
    ordy_a = 1;
    step();
    chk_cnt++;
    if ({ov_a, od_a, odst_a, inr_a} !== {1'b1, 8'h55, 4'h4, 1'b1})
      $display("FAIL bp_release: got v=%b d=%h dst=%h rdy=%b want 1 55 4 1", ov_a, od_a, odst_a, inr_a);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({ov_a, inr_a} !== {1'b0, 1'b1})
      $display("FAIL bp_empty: got v=%b rdy=%b want 0 1", ov_a, inr_a);
    else pass_cnt++;
  endtask

  task automatic test_bad_select();
    do_reset();
    ordy_a = 1; sel_a = 7; we_a = 1; inv_a = 1;
    step();
    chk_cnt++;
    if ({od_a, owe_a, serr_a, ecnt_a} !== {8'h11, 1'b0, 1'b1, 8'h01})
      $display("FAIL bad_sel: got d=%h we=%b err=%b cnt=%h want 11 0 1 01", od_a, owe_a, serr_a, ecnt_a);
    else pass_cnt++;
    // 254 more brings the count exactly to 0xFF
    repeat (254) step();
    chk_cnt++;
    if (ecnt_a !== 8'hFF) $display("FAIL bad_cnt255: got cnt=%h want ff", ecnt_a);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ecnt_a !== 8'hFF) $display("FAIL bad_saturate: got cnt=%h want ff", ecnt_a);
    else pass_cnt++;
    // Not-accepted bad selects must not count: stall with both stages full
    sel_a = 0; err_clr_pulse();
    ordy_a = 0; sel_a = 9;
    repeat (4) step();
    chk_cnt++;
    if ({inr_a, ecnt_a} !== {1'b0, 8'h02})
      $display("FAIL bad_unaccepted: got rdy=%b cnt=%h want 0 02", inr_a, ecnt_a);
    else pass_cnt++;
    inv_a = 0;
  endtask

  task automatic err_clr_pulse();
    inv_a = 0; clr_a = 1;
    step();
    clr_a = 0; inv_a = 1;
  endtask

  task automatic test_err_clr();
    do_reset();
    ordy_a = 1; we_a = 1; sel_a = 8; inv_a = 1;
    repeat (3) step();
    clr_a = 1;
    step();
    chk_cnt++;
    if ({serr_a, ecnt_a} !== {1'b1, 8'h01})
      $display("FAIL clr_with_bad: got err=%b cnt=%h want 1 01", serr_a, ecnt_a);
    else pass_cnt++;
    inv_a = 0;
    step();
    chk_cnt++;
    if ({serr_a, ecnt_a} !== {1'b0, 8'h00})
      $display("FAIL clr_only: got err=%b cnt=%h want 0 00", serr_a, ecnt_a);
    else pass_cnt++;
    clr_a = 0;
  endtask

  task automatic test_flush();
    do_reset();
    ordy_a = 1; we_a = 1; sel_a = 5; inv_a = 1;
    step();                                   // one bad beat -> count 1
    ordy_a = 0; sel_a = 1;
    step();
    sel_a = 3;
    step();                                   // both stages full
    chk_cnt++;
    if ({ov_a, inr_a, ecnt_a} !== {1'b1, 1'b0, 8'h01})
      $display("FAIL flush_pre: got v=%b rdy=%b cnt=%h want 1 0 01", ov_a, inr_a, ecnt_a);
    else pass_cnt++;
    flush_a = 1; sel_a = 0;
    step();
    chk_cnt++;
    if ({ov_a, inr_a, ecnt_a, serr_a} !== {1'b0, 1'b1, 8'h01, 1'b1})
      $display("FAIL flush: got v=%b rdy=%b cnt=%h err=%b want 0 1 01 1", ov_a, inr_a, ecnt_a, serr_a);
    else pass_cnt++;
    flush_a = 0; inv_a = 0; ordy_a = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_cnt++;
      if (ov_a !== 1'b0) $display("FAIL flush_after%0d: out_valid=%b want 0", c, ov_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ordy_a = 0; we_a = 1; sel_a = 3; inv_a = 1;
    step();
    sel_a = 4;
    step();
    inv_a = 0;
    #2 rst_n = 0;
    #1;
    chk_cnt++;
    if ({ov_a, inr_a, od_a, ecnt_a} !== {1'b0, 1'b1, 8'h00, 8'h00})
      $display("FAIL async_reset: got v=%b rdy=%b d=%h cnt=%h want 0 1 00 00", ov_a, inr_a, od_a, ecnt_a);
    else pass_cnt++;
    #2 rst_n = 1;
    ordy_a = 1;
    step();
    chk_cnt++;
    if (ov_a !== 1'b0) $display("FAIL async_after: out_valid=%b want 0", ov_a);
    else pass_cnt++;
  endtask

  task automatic test_wide_select();
    logic [15:0] exp_d;
    do_reset();
    ordy_b = 1; we_b = 1; inv_b = 1;
    for (int k = 0; k < 13; k++) begin
      sel_b = 4'(k); dest_b = 4'(15 - k);
      exp_d = (k < 12) ? 16'(16'h0101 * (k + 1)) : 16'h0101;  // 12 -> source 0
      step();
      chk_cnt++;
      if ({ov_b, inr_b, od_b, odst_b, owe_b, serr_b} !== {1'b1, 1'b1, exp_d, 4'(15 - k), (k < 12), (k == 12)})
        $display("FAIL wide_sel%0d: got v=%b rdy=%b d=%h dst=%h we=%b err=%b want 1 1 %h %h %b %b",
                 k, ov_b, inr_b, od_b, odst_b, owe_b, serr_b, exp_d, 4'(15 - k), (k < 12), (k == 12));
      else pass_cnt++;
    end
    inv_b = 0;
  endtask

  initial begin
    src_a = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 12; k++) src_b[k*16 +: 16] = 16'(16'h0101 * (k + 1));
    rst_n = 1;
    test_reset();
    test_basic_select();
    test_backpressure();
    test_bad_select();
    test_err_clr();
    test_flush();
    test_async_reset();
    test_wide_select();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
